// File: rtl/mac_cluster_seq_pkg.sv
// Shared types and constants for the MAC cluster: FSM states, mode-bit indices
// and the configuration beat-count helper.
package mac_cluster_seq_pkg;

    localparam int MODE_SIGNED = 0;
    localparam int MODE_MAC    = 1;
    localparam int MODE_SAT    = 2;
    localparam int MODE_DUMP   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/mac_cluster_seq_lane.sv
// One MAC lane: operand stage, multiply with sign/zero extension, accumulate
// with wrap or saturate, and a sticky overflow flag.
module mac_cluster_seq_lane
    import mac_cluster_seq_pkg::*;
#(
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic                     fire,
    input  logic                     commit,
    input  logic                     dump,
    input  logic                     is_signed,
    input  logic                     is_mac,
    input  logic                     is_sat,
    input  logic [MAC_MIN_WIDTH-1:0] a,
    input  logic [MAC_MIN_WIDTH-1:0] b,
    input  logic [MAC_ACC_WIDTH-1:0] init,
    output logic [MAC_ACC_WIDTH-1:0] res,
    output logic                     ovf
);

    localparam int EXT_W = MAC_ACC_WIDTH + 1;

    logic [MAC_MIN_WIDTH-1:0]        a_r;
    logic [MAC_MIN_WIDTH-1:0]        b_r;
    logic [MAC_ACC_WIDTH-1:0]        acc_r;
    logic [MAC_ACC_WIDTH-1:0]        res_r;
    logic                            ovf_r;

    logic signed [MAC_MULT_WIDTH-1:0] prod_sgn_s;
    logic [MAC_MULT_WIDTH-1:0]        prod_uns_s;
    logic [EXT_W-1:0]                 prod_ext_s;
    logic [EXT_W-1:0]                 acc_ext_s;
    logic [EXT_W-1:0]                 sum_s;
    logic [MAC_ACC_WIDTH-1:0]         sat_val_s;
    logic [MAC_ACC_WIDTH-1:0]         mac_res_s;
    logic                             ovf_s;

    // Product, one-bit-wider accumulate, overflow detection and clamp value
    always_comb begin
        prod_sgn_s = MAC_MULT_WIDTH'($signed(a_r)) * MAC_MULT_WIDTH'($signed(b_r));
        prod_uns_s = MAC_MULT_WIDTH'(a_r) * MAC_MULT_WIDTH'(b_r);
        if (is_signed) begin
            prod_ext_s = EXT_W'(prod_sgn_s);
            acc_ext_s  = {acc_r[MAC_ACC_WIDTH-1], acc_r};
        end else begin
            prod_ext_s = EXT_W'(prod_uns_s);
            acc_ext_s  = {1'b0, acc_r};
        end
        sum_s = acc_ext_s + prod_ext_s;
        // The spare top bit disagrees with the sign bit exactly when the signed range is left
        if (is_signed) begin
            ovf_s = sum_s[MAC_ACC_WIDTH] ^ sum_s[MAC_ACC_WIDTH-1];
            if (sum_s[MAC_ACC_WIDTH]) begin
                sat_val_s = {1'b1, {(MAC_ACC_WIDTH-1){1'b0}}};
            end else begin
                sat_val_s = {1'b0, {(MAC_ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            ovf_s     = sum_s[MAC_ACC_WIDTH];
            sat_val_s = {MAC_ACC_WIDTH{1'b1}};
        end
        if (ovf_s && is_sat) begin
            mac_res_s = sat_val_s;
        end else begin
            mac_res_s = sum_s[MAC_ACC_WIDTH-1:0];
        end
    end

    // S1 operand capture and S2 result/accumulator update
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {MAC_MIN_WIDTH{1'b0}};
            b_r   <= {MAC_MIN_WIDTH{1'b0}};
            acc_r <= {MAC_ACC_WIDTH{1'b0}};
            res_r <= {MAC_ACC_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (en) begin
            if (load) begin
                a_r <= a;
                b_r <= b;
            end
            if (commit) begin
                acc_r <= init;
                ovf_r <= 1'b0;
            end else if (fire) begin
                if (is_mac) begin
                    res_r <= mac_res_s;
                    if (dump) begin
                        acc_r <= init;
                    end else begin
                        acc_r <= mac_res_s;
                    end
                    if (ovf_s) begin
                        ovf_r <= 1'b1;
                    end
                end else begin
                    res_r <= prod_ext_s[MAC_ACC_WIDTH-1:0];
                end
            end
        end
    end

    assign res = res_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/mac_cluster_seq.sv
// N-lane MAC cluster: serial config loader FSM, operand handshake, shared
// beat/dump counters, and the generated lane array.
module mac_cluster_seq
    import mac_cluster_seq_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH,
    parameter int MAC_CONF_WIDTH = 4,
    parameter int DUMP_LEN_WIDTH = 8,
    parameter int CFG_BUS_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 cset,
    input  logic [CFG_BUS_WIDTH-1:0]             cfg,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0]   A,
    input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0]   B,
    output logic [NUM_LANES*MAC_ACC_WIDTH-1:0]   out,
    output logic                                 out_valid,
    output logic                                 out_last,
    output logic [NUM_LANES-1:0]                 ovf,
    output logic                                 cfg_busy,
    output logic                                 configured
);

    localparam int INIT_OFF  = MAC_CONF_WIDTH + DUMP_LEN_WIDTH;
    localparam int INIT_W    = NUM_LANES * MAC_ACC_WIDTH;
    localparam int CW_W      = INIT_OFF + INIT_W;
    localparam int CFG_BEATS = ceil_div(CW_W, CFG_BUS_WIDTH);
    localparam int SHR_W     = (CFG_BEATS - 1) * CFG_BUS_WIDTH;
    localparam int BEAT_W    = $clog2(CFG_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CFG_BEATS - 1);

    state_t                    state_r;
    logic [SHR_W-1:0]          shadow_r;
    logic [BEAT_W-1:0]         beat_r;
    logic [MAC_CONF_WIDTH-1:0] mode_r;
    logic [DUMP_LEN_WIDTH-1:0] dump_len_r;
    logic [DUMP_LEN_WIDTH-1:0] dump_cnt_r;
    logic [INIT_W-1:0]         init_r;
    logic                      configured_r;
    logic                      cfg_busy_r;
    logic                      s1_valid_r;
    logic                      out_valid_r;
    logic                      out_last_r;

    logic                      in_ready_s;
    logic                      accept_s;
    logic                      commit_s;
    logic                      dump_hit_s;
    logic [SHR_W-1:0]          shadow_shift_s;
    logic [CW_W-1:0]           cw_s;
    logic [INIT_W-1:0]         lane_init_s;

    // Handshake, commit detection, dump decision and the config word as it will be committed
    always_comb begin
        in_ready_s     = en & (state_r == ST_RUN);
        accept_s       = in_valid & in_ready_s;
        commit_s       = en & cset & (state_r == ST_LOAD) & (beat_r == LAST_BEAT);
        shadow_shift_s = {cfg, shadow_r[SHR_W-1:CFG_BUS_WIDTH]};
        // The final beat is still on the bus at commit, so it completes the word from the top
        cw_s           = CW_W'({cfg, shadow_r});
        if (mode_r[MODE_DUMP] && (dump_len_r != {DUMP_LEN_WIDTH{1'b0}})) begin
            dump_hit_s = (dump_cnt_r == (dump_len_r - DUMP_LEN_WIDTH'(1)));
        end else begin
            dump_hit_s = 1'b0;
        end
        if (commit_s) begin
            lane_init_s = cw_s[CW_W-1:INIT_OFF];
        end else begin
            lane_init_s = init_r;
        end
    end

    // Config FSM, shadow shift register, pipeline valid tracking and dump counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shadow_r     <= {SHR_W{1'b0}};
            beat_r       <= {BEAT_W{1'b0}};
            mode_r       <= {MAC_CONF_WIDTH{1'b0}};
            dump_len_r   <= {DUMP_LEN_WIDTH{1'b0}};
            dump_cnt_r   <= {DUMP_LEN_WIDTH{1'b0}};
            init_r       <= {INIT_W{1'b0}};
            configured_r <= 1'b0;
            cfg_busy_r   <= 1'b0;
            s1_valid_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
        end else if (en) begin
            s1_valid_r  <= accept_s;
            out_valid_r <= s1_valid_r;
            out_last_r  <= s1_valid_r & dump_hit_s;
            if (s1_valid_r && mode_r[MODE_DUMP]) begin
                if (dump_hit_s) begin
                    dump_cnt_r <= {DUMP_LEN_WIDTH{1'b0}};
                end else begin
                    dump_cnt_r <= dump_cnt_r + DUMP_LEN_WIDTH'(1);
                end
            end
            case (state_r)
                ST_IDLE, ST_RUN: begin
                    if (cset) begin
                        shadow_r   <= shadow_shift_s;
                        beat_r     <= BEAT_W'(1);
                        cfg_busy_r <= 1'b1;
                        state_r    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cset && (beat_r == LAST_BEAT)) begin
                        mode_r       <= cw_s[MAC_CONF_WIDTH-1:0];
                        dump_len_r   <= cw_s[MAC_CONF_WIDTH +: DUMP_LEN_WIDTH];
                        init_r       <= cw_s[CW_W-1:INIT_OFF];
                        dump_cnt_r   <= {DUMP_LEN_WIDTH{1'b0}};
                        shadow_r     <= {SHR_W{1'b0}};
                        beat_r       <= {BEAT_W{1'b0}};
                        configured_r <= 1'b1;
                        cfg_busy_r   <= 1'b0;
                        state_r      <= ST_RUN;
                    end else if (cset) begin
                        shadow_r <= shadow_shift_s;
                        beat_r   <= beat_r + BEAT_W'(1);
                    end else begin
                        // Aborted load: partial word is thrown away, old config stays live
                        shadow_r   <= {SHR_W{1'b0}};
                        beat_r     <= {BEAT_W{1'b0}};
                        cfg_busy_r <= 1'b0;
                        if (configured_r) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    beat_r     <= {BEAT_W{1'b0}};
                    cfg_busy_r <= 1'b0;
                end
            endcase
        end else begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mac_cluster_seq_lane #(
            .MAC_MIN_WIDTH (MAC_MIN_WIDTH),
            .MAC_MULT_WIDTH(MAC_MULT_WIDTH),
            .MAC_ACC_WIDTH (MAC_ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (accept_s),
            .fire     (s1_valid_r),
            .commit   (commit_s),
            .dump     (dump_hit_s),
            .is_signed(mode_r[MODE_SIGNED]),
            .is_mac   (mode_r[MODE_MAC]),
            .is_sat   (mode_r[MODE_SAT]),
            .a        (A[i*MAC_MIN_WIDTH +: MAC_MIN_WIDTH]),
            .b        (B[i*MAC_MIN_WIDTH +: MAC_MIN_WIDTH]),
            .init     (lane_init_s[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH]),
            .res      (out[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH]),
            .ovf      (ovf[i])
        );
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign cfg_busy   = cfg_busy_r;
    assign configured = configured_r;

endmodule

// File: tb/tb_mac_cluster_seq.sv
// Directed bench for mac_cluster_seq: config loading, MAC/MUL arithmetic,
// saturation, auto-dump, aborted loads, enable freeze and reset.
module tb_mac_cluster_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cset;
    logic [7:0]   cfg;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  A;
    logic [31:0]  B;
    logic [127:0] out;
    logic         out_valid;
    logic         out_last;
    logic [3:0]   ovf;
    logic         cfg_busy;
    logic         configured;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_cluster_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cset      (cset),
        .cfg       (cfg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .ovf       (ovf),
        .cfg_busy  (cfg_busy),
        .configured(configured)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift a full config word in, LSB beat first: 18 beats of 8 bits
    task automatic load_cfg(input logic [3:0] mode, input logic [7:0] dl, input logic [127:0] init);
        logic [143:0] cw;
        cw = {4'b0000, init, dl, mode};
        for (int k = 0; k < 18; k++) begin
            cset = 1'b1;
            cfg  = cw[k*8 +: 8];
            tick();
        end
        cset = 1'b0;
        cfg  = 8'h00;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cset = 1'b0; cfg = 8'h00;
        in_valid = 1'b1; A = 32'h0; B = 32'h0;
        tick(); tick();
        chk("rst_out", out[63:0], 64'h0);
        chk("rst_out_valid", out_valid, 64'h0);
        chk("rst_ovf", ovf, 64'h0);
        chk("rst_configured", configured, 64'h0);
        rst = 1'b0;

        // Unconfigured: never ready, never valid
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_in_ready", in_ready, 64'h0);
            chk("idle_out_valid", out_valid, 64'h0);
            chk("idle_configured", configured, 64'h0);
        end
        in_valid = 1'b0;

        // Unsigned MAC with auto-dump every 3 beats
        load_cfg(4'b1010, 8'd3, 128'h0);
        chk("cfg_configured", configured, 64'h1);
        chk("cfg_busy_done", cfg_busy, 64'h0);
        chk("cfg_in_ready", in_ready, 64'h1);
        A = 32'h0000_0003; B = 32'h0000_0004;
        in_valid = 1'b1;
        tick();
        chk("mac_lat_valid", out_valid, 64'h0);
        tick();
        chk("mac_b1", out[31:0], 64'd12);
        chk("mac_b1_last", out_last, 64'h0);
        tick();
        chk("mac_b2", out[31:0], 64'd24);
        tick();
        chk("mac_b3", out[31:0], 64'd36);
        chk("mac_b3_last", out_last, 64'h1);
        in_valid = 1'b0;
        tick();
        chk("mac_b4", out[31:0], 64'd12);
        chk("mac_b4_last", out_last, 64'h0);
        tick();
        chk("mac_drained", out_valid, 64'h0);

        // Signed MUL on lane 1
        load_cfg(4'b0001, 8'd0, 128'h0);
        A = 32'h0000_FF00; B = 32'h0000_0200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mul_lat1", out_valid, 64'h0);
        tick();
        chk("mul_valid", out_valid, 64'h1);
        chk("mul_lane1", out[63:32], 64'hFFFF_FFFE);
        chk("mul_lane0", out[31:0], 64'h0);

        // Enable low freezes the in-flight beat for one cycle
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        en = 1'b0;
        tick();
        chk("en0_out_valid", out_valid, 64'h0);
        chk("en0_in_ready", in_ready, 64'h0);
        en = 1'b1;
        tick();
        chk("en1_out_valid", out_valid, 64'h1);
        chk("en1_lane1", out[63:32], 64'hFFFF_FFFE);
        tick();
        chk("en1_pulse", out_valid, 64'h0);

        // Signed saturating MAC from near the positive limit
        load_cfg(4'b0111, 8'd0, {96'h0, 32'h7FFF_FFF0});
        chk("sat_ovf_clear", ovf, 64'h0);
        A = 32'h0000_007F; B = 32'h0000_007F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_out", out[31:0], 64'h7FFF_FFFF);
        chk("sat_ovf", ovf, 64'h1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_out2", out[31:0], 64'h7FFF_FFFF);

        // Same start, wrapping: 0x7FFFFFF0 + 0x3F01
        load_cfg(4'b0011, 8'd0, {96'h0, 32'h7FFF_FFF0});
        chk("wrap_ovf_clear", ovf, 64'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_out", out[31:0], 64'h8000_3EF1);
        chk("wrap_ovf", ovf, 64'h1);

        // Aborted load after 5 beats keeps old config and accumulator
        cset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_busy", cfg_busy, 64'h1);
            chk("abort_no_ready", in_ready, 64'h0);
        end
        cset = 1'b0;
        tick();
        chk("abort_busy_low", cfg_busy, 64'h0);
        chk("abort_in_ready", in_ready, 64'h1);
        chk("abort_configured", configured, 64'h1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("abort_acc", out[31:0], 64'h8000_7DF2);
        chk("abort_ovf_sticky", ovf, 64'h1);

        // Beat accepted on the cset edge drains during LOAD; reset at beat 9
        cset = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("load_in_ready", in_ready, 64'h0);
        chk("load_busy", cfg_busy, 64'h1);
        tick();
        chk("drain_valid", out_valid, 64'h1);
        chk("drain_acc", out[31:0], 64'h8000_BCF3);
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        chk("mrst_out_lo", out[63:0], 64'h0);
        chk("mrst_out_hi", out[127:64], 64'h0);
        chk("mrst_valid", out_valid, 64'h0);
        chk("mrst_last", out_last, 64'h0);
        chk("mrst_ovf", ovf, 64'h0);
        chk("mrst_busy", cfg_busy, 64'h0);
        chk("mrst_configured", configured, 64'h0);
        rst = 1'b0;
        cset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_ready", in_ready, 64'h0);
            chk("post_rst_valid", out_valid, 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
